// File: rtl/clk_tick_sched.sv
// Shared power-of-two divider: per-channel square waves and tick enables.
// Rate changes take effect only on period boundaries, so no runt pulses occur.
`timescale 1ns/1ps
module clk_tick_sched #(
  parameter int NCH   = 4,
  parameter int CNT_W = 27
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [2:0]     cfg_ch,
  input  logic [4:0]     cfg_exp,
  input  logic           cfg_en,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] tick,
  output logic           pend
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [4:0] EMAX = 5'(CNT_W - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [NCH-1:0]   r_en;
  logic [NCH-1:0]   w_en_nxt;
  logic [4:0]       r_exp     [NCH];
  logic [4:0]       w_exp_nxt [NCH];

  logic [2:0]       r_pch;
  logic [4:0]       r_pexp;
  logic             r_pen;
  logic [4:0]       r_bexp;
  logic             r_imm;

  logic             w_ch_ok;
  logic             w_accept;
  logic             w_commit;
  logic [4:0]       w_cexp;
  logic             w_old_en;
  logic [4:0]       w_old_exp;
  logic [4:0]       w_bexp;
  logic             w_imm;

  logic             r_ready;
  logic             r_pend;
  logic [NCH-1:0]   r_level;
  logic [NCH-1:0]   r_tick;
  logic [NCH-1:0]   w_level;
  logic [NCH-1:0]   w_tick;

  // True when c[e:0] is all zero, i.e. c sits on a period boundary of e.
  function automatic logic f_bnd(
    input logic [CNT_W-1:0] c,
    input logic [4:0]       e
  );
    logic [CNT_W:0] m;
    m = ((CNT_W+1)'(1) << ({1'b0, e} + 6'd1)) - (CNT_W+1)'(1);
    return (({1'b0, c} & m) == '0);
  endfunction

  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  always_comb begin
    w_ch_ok = (32'(cfg_ch) < NCH);
    w_cexp  = (cfg_exp > EMAX) ? EMAX : cfg_exp;
  end

  always_comb begin
    w_old_en  = 1'b0;
    w_old_exp = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == 3'(i)) begin
        w_old_en  = r_en[i];
        w_old_exp = r_exp[i];
      end
    end
  end

  // Boundary exponent is fixed at acceptance; only a commit can
  // change the target channel, so it cannot go stale while waiting.
  always_comb begin
    w_bexp = w_cexp;
    w_imm  = 1'b0;
    if (cfg_en) begin
      if (w_old_en && (w_old_exp > w_cexp)) begin
        w_bexp = w_old_exp;
      end
    end else begin
      w_bexp = w_old_exp;
      w_imm  = ~w_old_en;
    end
  end

  always_comb begin
    w_commit = (r_state == S_WAIT) &&
               (r_imm || f_bnd(w_cnt_nxt, r_bexp));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cfg_valid && w_ch_ok) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_commit) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_en_nxt = r_en;
    for (int i = 0; i < NCH; i++) begin
      w_exp_nxt[i] = r_exp[i];
      if (w_commit && (r_pch == 3'(i))) begin
        w_en_nxt[i]  = r_pen;
        w_exp_nxt[i] = r_pexp;
      end
    end
  end

  // Outputs follow the post-edge counter and config with no extra lag.
  always_comb begin
    w_level = '0;
    w_tick  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_level[i] = w_en_nxt[i] &
                   (|(w_cnt_nxt & (CNT_W'(1) << w_exp_nxt[i])));
      w_tick[i]  = w_en_nxt[i] & f_bnd(w_cnt_nxt, w_exp_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_en    <= '0;
      r_level <= '0;
      r_tick  <= '0;
      r_ready <= 1'b1;
      r_pend  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_exp[i] <= '0;
      end
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
      r_level <= w_level;
      r_tick  <= w_tick;
      r_ready <= (w_state_nxt == S_IDLE);
      r_pend  <= (w_state_nxt == S_WAIT);
      for (int i = 0; i < NCH; i++) begin
        r_exp[i] <= w_exp_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pch  <= '0;
      r_pexp <= '0;
      r_pen  <= 1'b0;
      r_bexp <= '0;
      r_imm  <= 1'b0;
    end else if (w_accept) begin
      r_pch  <= cfg_ch;
      r_pexp <= w_cexp;
      r_pen  <= cfg_en;
      r_bexp <= w_bexp;
      r_imm  <= w_imm;
    end
  end

  assign cfg_ready = r_ready;
  assign pend      = r_pend;
  assign level     = r_level;
  assign tick      = r_tick;

endmodule

// File: tb/tb_clk_tick_sched.sv
// Directed bench for clk_tick_sched with NCH=4, CNT_W=8.
`timescale 1ns/1ps
module tb_clk_tick_sched;

  logic       clk;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_ch;
  logic [4:0] cfg_exp;
  logic       cfg_en;
  logic [3:0] level;
  logic [3:0] tick;
  logic       pend;

  logic [7:0] tb_cnt;
  int         n_checks;
  int         n_fail;
  int         m_en [4];
  int         m_e  [4];

  clk_tick_sched #(.NCH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_exp   (cfg_exp),
    .cfg_en    (cfg_en),
    .level     (level),
    .tick      (tick),
    .pend      (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= 8'd0;
    else       tb_cnt <= tb_cnt + 8'd1;
  end

  function automatic logic [9:0] f_exp(input int c, input logic rdy,
                                       input logic pnd);
    logic [3:0] lv;
    logic [3:0] tk;
    for (int i = 0; i < 4; i++) begin
      lv[i] = (m_en[i] != 0) && (((c >> m_e[i]) & 1) != 0);
      tk[i] = (m_en[i] != 0) && ((c % (2 << m_e[i])) == 0);
    end
    return {lv, tk, rdy, pnd};
  endfunction

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    while (int'(tb_cnt) != v && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (int'(tb_cnt) != v) begin
      n_fail++;
      $display("FAIL wait_cnt got=%0d exp=%0d", tb_cnt, v);
    end
  endtask

  task automatic drive(input logic v, input int ch, input int e,
                       input logic en);
    cfg_valid = v;
    cfg_ch    = 3'(ch);
    cfg_exp   = 5'(e);
    cfg_en    = en;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 0;
      m_e[i]  = 0;
    end
    drive(1'b0, 0, 0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got = {level, tick, cfg_ready, pend};
    n_checks++;
    if (got !== 10'b0000_0000_10) begin
      n_fail++;
      $display("FAIL reset_hold got=%b exp=%b", got, 10'b0000_0000_10);
    end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      got = {level, tick, cfg_ready, pend};
      n_checks++;
      if (got !== 10'b0000_0000_10) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got=%b exp=%b", k, got,
                 10'b0000_0000_10);
      end
    end
  endtask

  task automatic test_enable();
    logic [9:0] got;
    logic [9:0] exp;
    int c;
    wait_cnt(5);
    for (int k = 0; k < 4; k++) begin
      c = int'(tb_cnt);
      if (c >= 8) begin
        m_en[0] = 1;
        m_e[0]  = 2;
      end
      exp = f_exp(c, c == 5, (c == 6) || (c == 7));
      got = {level, tick, cfg_ready, pend};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL enable cnt=%0d got=%b exp=%b", c, got, exp);
      end
      if (c == 5) drive(1'b1, 0, 2, 1'b1);
      if (c == 6) drive(1'b0, 0, 0, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_rate_change();
    logic [9:0] got;
    logic [9:0] exp;
    int c;
    int k;
    wait_cnt(9);
    k = 0;
    while (int'(tb_cnt) <= 72 && k < 100) begin
      c = int'(tb_cnt);
      if (c >= 32) m_e[0] = 4;
      exp = f_exp(c, (c == 9) || (c >= 33), (c >= 10) && (c <= 31));
      got = {level, tick, cfg_ready, pend};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rate_change cnt=%0d got=%b exp=%b", c, got, exp);
      end
      if (c == 9)  drive(1'b1, 0, 4, 1'b1);
      if (c == 10) drive(1'b0, 0, 0, 1'b0);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] got;
    logic [9:0] exp;
    logic       rdy;
    logic       pnd;
    int c;
    int k;
    wait_cnt(73);
    k = 0;
    while (int'(tb_cnt) <= 100 && k < 100) begin
      c = int'(tb_cnt);
      if (c >= 80) begin
        m_en[2] = 1;
        m_e[2]  = 3;
      end
      if (c >= 84) begin
        m_en[1] = 1;
        m_e[1]  = 1;
      end
      rdy = (c == 73) || (c == 81) || (c >= 85);
      pnd = ((c >= 74) && (c <= 79)) || ((c >= 82) && (c <= 83));
      exp = f_exp(c, rdy, pnd);
      got = {level, tick, cfg_ready, pend};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cnt=%0d got=%b exp=%b", c, got, exp);
      end
      if (c == 73) drive(1'b1, 2, 3, 1'b1);
      if (c == 74) drive(1'b1, 1, 1, 1'b1);
      if (c == 82) drive(1'b0, 0, 0, 1'b0);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_disable_wrap();
    logic [9:0] got;
    logic [9:0] exp;
    logic       rdy;
    logic       pnd;
    logic       lap;
    int c;
    int k;
    wait_cnt(40);
    lap = 1'b0;
    k = 0;
    while (!(lap && int'(tb_cnt) == 11) && k < 400) begin
      c = int'(tb_cnt);
      lap = lap || (c < 40);
      if (lap || c >= 64) m_en[0] = 0;
      if (lap) begin
        m_en[3] = 1;
        m_e[3]  = 7;
      end
      rdy = !((!lap && c >= 41 && c <= 64) ||
              (!lap && c >= 67) || (lap && c == 0));
      pnd = (!lap && c >= 41 && c <= 63) || (!lap && c >= 67);
      exp = f_exp(c, rdy, pnd);
      got = {level, tick, cfg_ready, pend};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL disable_wrap cnt=%0d lap=%0d got=%b exp=%b",
                 c, lap, got, exp);
      end
      if (!lap && c == 40) drive(1'b1, 0, 4, 1'b0);
      if (!lap && c == 41) drive(1'b0, 0, 0, 1'b0);
      if (!lap && c == 66) drive(1'b1, 3, 31, 1'b1);
      if (!lap && c == 67) drive(1'b0, 0, 0, 1'b0);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset_wait();
    logic [9:0] got;
    logic [9:0] exp;
    int c;
    wait_cnt(20);
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_ready got=%b exp=1", cfg_ready);
    end
    drive(1'b1, 0, 5, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    n_checks++;
    if (pend !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_pend got=%b exp=1", pend);
    end
    wait_cnt(30);
    exp = f_exp(30, 1'b0, 1'b1);
    got = {level, tick, cfg_ready, pend};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL rw_prereset got=%b exp=%b", got, exp);
    end
    #2 reset = 1'b1;
    #1;
    got = {level, tick, cfg_ready, pend};
    n_checks++;
    if (got !== 10'b0000_0000_10) begin
      n_fail++;
      $display("FAIL rw_async got=%b exp=%b", got, 10'b0000_0000_10);
    end
    for (int i = 0; i < 4; i++) m_en[i] = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      c = int'(tb_cnt);
      got = {level, tick, cfg_ready, pend};
      n_checks++;
      if (got !== 10'b0000_0000_10) begin
        n_fail++;
        $display("FAIL rw_after cnt=%0d got=%b exp=%b", c, got,
                 10'b0000_0000_10);
      end
      if (c == 3) drive(1'b1, 5, 0, 1'b1);
      if (c == 4) drive(1'b0, 0, 0, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 0, 0, 1'b0);
    test_reset();
    test_enable();
    test_rate_change();
    test_back_to_back();
    test_disable_wrap();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
